spi_master_multi: RTL and testbench

SPI_MASTER_MULTI -- requirements
Module: spi_master_multi

---
 rtl/spi_master_multi.sv | 146 ++++++++++++++
 tb/tb_spi_master_multi.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_multi.sv
// SPI master with per-frame mode, length, clock divider and chip-select choice.
// A frame is SETUP (one half-period with CS asserted), XFER (2*len SCK edges),
// HOLD (one half-period before CS release). Frame settings are captured on accept.
module spi_master_multi #(
  parameter int DATA_WIDTH = 32,
  parameter int NCS        = 2,
  parameter int DIV_WIDTH  = 8,
  parameter int LEN_WIDTH  = $clog2(DATA_WIDTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  nrst,
  input  logic                                  start,
  input  logic [LEN_WIDTH-1:0]                  frame_len,
  input  logic [((NCS > 1) ? $clog2(NCS) : 1)-1:0] cs_sel,
  input  logic                                  cpol,
  input  logic                                  cpha,
  input  logic [DIV_WIDTH-1:0]                  clk_div,
  input  logic [DATA_WIDTH-1:0]                 tx_data,
  input  logic                                  sdi,
  output logic                                  sck,
  output logic                                  sdo,
  output logic [NCS-1:0]                        cs_n,
  output logic [DATA_WIDTH-1:0]                 rx_data,
  output logic                                  busy,
  output logic                                  done
);

  localparam int CSW = (NCS > 1) ? $clog2(NCS) : 1;

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_t;

  state_t                state, state_nx;
  logic [LEN_WIDTH-1:0]  len_in, len_q;
  logic [DIV_WIDTH-1:0]  div_q, div_cnt;
  logic [LEN_WIDTH:0]    edge_cnt, edge_last;
  logic                  cpha_q;
  logic [DATA_WIDTH-1:0] tx_aligned, tx_sh, rx_sh;
  logic [NCS-1:0]        cs_dec;
  logic                  accept, div_hit, last_edge, leading;

  assign len_in     = (frame_len > LEN_WIDTH'(DATA_WIDTH)) ? LEN_WIDTH'(DATA_WIDTH) : frame_len;
  // Frame is MSB-aligned in the shift register so the next bit is always at the top.
  assign tx_aligned = tx_data << (DATA_WIDTH - int'(len_in));
  assign accept     = start && (state == IDLE) && (frame_len != '0);
  assign div_hit    = (div_cnt == div_q);
  assign edge_last  = {len_q, 1'b0} - (LEN_WIDTH + 1)'(1);
  assign last_edge  = (edge_cnt == edge_last);
  assign leading    = ~edge_cnt[0];

  // Decode the requested chip select; out-of-range indices select nothing.
  always_comb begin
    cs_dec = '1;
    for (int unsigned i = 0; i < NCS; i++) begin
      if (cs_sel == CSW'(i)) cs_dec[i] = 1'b0;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state <= IDLE;
    else       state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept)               state_nx = SETUP;
      SETUP:   if (div_hit)              state_nx = XFER;
      XFER:    if (div_hit && last_edge) state_nx = HOLD;
      HOLD:    if (div_hit)              state_nx = IDLE;
      default:                           state_nx = IDLE;
    endcase
  end

  // Frame datapath: capture, SCK generation, shifting and completion.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      len_q    <= '0;
      div_q    <= '0;
      div_cnt  <= '0;
      edge_cnt <= '0;
      cpha_q   <= 1'b0;
      tx_sh    <= '0;
      rx_sh    <= '0;
      rx_data  <= '0;
      sck      <= 1'b0;
      sdo      <= 1'b0;
      cs_n     <= '1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            len_q    <= len_in;
            div_q    <= clk_div;
            cpha_q   <= cpha;
            tx_sh    <= tx_aligned;
            rx_sh    <= '0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            busy     <= 1'b1;
            cs_n     <= cs_dec;
            sck      <= cpol;
            sdo      <= tx_aligned[DATA_WIDTH-1];
          end
        end
        SETUP: div_cnt <= div_hit ? '0 : div_cnt + DIV_WIDTH'(1);
        XFER: begin
          if (div_hit) begin
            div_cnt  <= '0;
            sck      <= ~sck;
            edge_cnt <= edge_cnt + (LEN_WIDTH + 1)'(1);
            if (leading ^ cpha_q) rx_sh <= {rx_sh[DATA_WIDTH-2:0], sdi};
            // cpha=1 re-presents the top bit on the first leading edge, then shifts;
            // cpha=0 already presented it at accept, so it shifts on trailing edges.
            if (cpha_q && leading) begin
              sdo   <= tx_sh[DATA_WIDTH-1];
              tx_sh <= tx_sh << 1;
            end else if (!cpha_q && !leading && !last_edge) begin
              sdo   <= tx_sh[DATA_WIDTH-2];
              tx_sh <= tx_sh << 1;
            end
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        HOLD: begin
          if (div_hit) begin
            div_cnt <= '0;
            busy    <= 1'b0;
            done    <= 1'b1;
            cs_n    <= '1;
            rx_data <= rx_sh;
          end else begin
            div_cnt <= div_cnt + DIV_WIDTH'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master_multi.sv
// Randomized bench for spi_master_multi with a bit-level SPI slave model.
module tb_spi_master_multi;
  localparam int DW  = 32;
  localparam int NCS = 3;
  localparam int LW  = 6;

  logic          clk = 1'b0, nrst = 1'b0, start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic [1:0]    cs_sel = '0;
  logic          cpol = 1'b0, cpha = 1'b0;
  logic [7:0]    clk_div = '0;
  logic [DW-1:0] tx_data = '0;
  logic          sdi, sck, sdo, busy, done;
  logic [NCS-1:0] cs_n;
  logic [DW-1:0] rx_data;

  int checks = 0, failures = 0;

  // Slave model state: word it returns and frame shape it expects.
  int            cur_len = 1;
  bit            cur_pha = 1'b0;
  logic [DW-1:0] slave_word = '0;
  bit            loopback = 1'b0;
  int            s_e = 0;
  logic          s_prev_sck = 1'b0, s_prev_busy = 1'b0;
  logic          slave_bit;

  spi_master_multi #(.DATA_WIDTH(DW), .NCS(NCS), .DIV_WIDTH(8)) dut (
    .clk(clk), .nrst(nrst), .start(start), .frame_len(frame_len), .cs_sel(cs_sel),
    .cpol(cpol), .cpha(cpha), .clk_div(clk_div), .tx_data(tx_data), .sdi(sdi),
    .sck(sck), .sdo(sdo), .cs_n(cs_n), .rx_data(rx_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bit the slave presents after e SCK edges: cpha=0 advances after each trailing
  // edge, cpha=1 advances on each leading edge (first one shows the MSB).
  function automatic logic slave_pick(input int e, input int len, input bit pha,
                                      input logic [DW-1:0] w);
    int idx;
    idx = pha ? len - (e + 1) / 2 : len - 1 - e / 2;
    if (idx >= 0 && idx < len) return w[idx];
    else return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (busy && !s_prev_busy)           s_e <= 0;
    else if (busy && sck !== s_prev_sck) s_e <= s_e + 1;
    s_prev_sck  <= sck;
    s_prev_busy <= busy;
  end

  always_comb slave_bit = slave_pick(s_e, cur_len, cur_pha, slave_word);
  assign sdi = loopback ? sdo : slave_bit;

  function automatic logic [NCS-1:0] exp_cs(input int sel);
    logic [NCS-1:0] one;
    one = 1;
    if (sel < NCS) return ~(one << sel);
    else return '1;
  endfunction

  task automatic run_frame(input int lreq, input int sel, input bit pol, input bit pha,
                           input int div, input logic [DW-1:0] tx, input logic [DW-1:0] sw,
                           input bit loop, input bit disturb);
    int leff, busy_cnt, edges, gap, bad_gap, cs_bad, cyc, k, late_busy;
    logic [DW-1:0] mask, cap;
    logic [NCS-1:0] ecs;
    logic ps, psdo;
    bit fin;
    leff = (lreq > DW) ? DW : lreq;
    mask = (leff == DW) ? '1 : ((32'd1 << leff) - 32'd1);
    ecs  = exp_cs(sel);
    @(negedge clk);
    cur_len = leff; cur_pha = pha; slave_word = sw; loopback = loop;
    frame_len = LW'(lreq); cs_sel = 2'(sel); cpol = pol; cpha = pha;
    clk_div = 8'(div); tx_data = tx; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy_cnt = 0; edges = 0; gap = 0; bad_gap = 0; cs_bad = 0; cyc = 0; cap = '0;
    ps = pol; psdo = tx[leff-1]; fin = 1'b0;
    while (!fin) begin
      if (busy) begin
        busy_cnt++;
        if (cs_n !== ecs) cs_bad++;
      end
      gap++;
      if (sck !== ps) begin
        k = edges;
        edges++;
        if (edges > 1 && gap != div + 1) bad_gap++;
        gap = 0;
        if ((k % 2) == int'(pha)) cap = {cap[DW-2:0], psdo};
      end
      ps = sck; psdo = sdo;
      if (disturb && cyc == 6) begin
        start = 1'b1; tx_data = ~tx; cpol = ~pol; frame_len = 6'd3;
      end
      if (disturb && cyc == 7) start = 1'b0;
      if (done) fin = 1'b1;
      else if (cyc > 3000) begin
        fin = 1'b1;
        chk_eq("done_timeout", 1, 0);
      end else begin
        @(negedge clk);
        cyc++;
      end
    end
    chk_eq("busy_cycles", busy_cnt, (2 * leff + 2) * (div + 1));
    chk_eq("sck_edges", edges, 2 * leff);
    chk_eq("half_period", bad_gap, 0);
    chk_eq("cs_during_frame", cs_bad, 0);
    chk_eq("sdo_bits", cap & mask, tx & mask);
    chk_eq("rx_data", rx_data, (loop ? tx : sw) & mask);
    chk_eq("sck_idle", sck, pol);
    @(negedge clk);
    chk_eq("done_width", done, 0);
    chk_eq("cs_release", cs_n, {NCS{1'b1}});
    chk_eq("busy_release", busy, 0);
    if (disturb) begin
      late_busy = 0;
      repeat (6) begin
        @(negedge clk);
        if (busy || done) late_busy++;
      end
      chk_eq("no_requeue", late_busy, 0);
    end
  endtask

  task automatic abort_frame();
    int edges, n, dn;
    logic ps;
    @(negedge clk);
    cur_len = 16; cur_pha = 1'b0; slave_word = 32'h1234; loopback = 1'b0;
    frame_len = 6'd16; cs_sel = 2'd0; cpol = 1'b0; cpha = 1'b0; clk_div = 8'd1;
    tx_data = 32'h0000_F00D; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ps = sck; edges = 0; n = 0; dn = 0;
    while (edges < 10 && n < 500) begin
      @(negedge clk);
      n++;
      if (sck !== ps) edges++;
      ps = sck;
    end
    chk_eq("abort_reach_bit5", edges, 10);
    nrst = 1'b0;
    #1;
    chk_eq("abort_sck", sck, 0);
    chk_eq("abort_sdo", sdo, 0);
    chk_eq("abort_cs_n", cs_n, {NCS{1'b1}});
    chk_eq("abort_busy", busy, 0);
    chk_eq("abort_rx", rx_data, 0);
    repeat (3) begin
      @(negedge clk);
      if (done) dn++;
    end
    nrst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    chk_eq("abort_no_done", dn, 0);
  endtask

  initial begin
    int act;
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk_eq("rst_sck", sck, 0);
    chk_eq("rst_sdo", sdo, 0);
    chk_eq("rst_cs_n", cs_n, {NCS{1'b1}});
    chk_eq("rst_busy", busy, 0);
    chk_eq("rst_done", done, 0);
    chk_eq("rst_rx", rx_data, 0);
    nrst = 1'b1;
    @(negedge clk);

    // Mode 0, slow clock, short frame with slave data.
    run_frame(8, 0, 1'b0, 1'b0, 1, 32'h0000_00A5, 32'h0000_003C, 1'b0, 1'b0);
    // Mode 3, fastest clock, full-width loopback.
    run_frame(32, 1, 1'b1, 1'b1, 0, 32'hDEAD_BEEF, 32'h0, 1'b1, 1'b0);

    // Zero-length request is ignored.
    @(negedge clk);
    frame_len = '0; start = 1'b1;
    act = 0;
    repeat (12) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || done || cs_n !== {NCS{1'b1}}) act++;
    end
    chk_eq("len0_ignored", act, 0);

    // Over-length request clamps to full width.
    run_frame(40, 0, 1'b0, 1'b1, 0, $urandom, $urandom, 1'b0, 1'b0);
    // Mid-frame start and input changes must not affect the frame.
    run_frame(16, 2, 1'b0, 1'b1, 1, 32'h0000_C3A7, 32'h0000_5A5A, 1'b0, 1'b1);
    // Reset mid-frame, then a clean frame.
    abort_frame();
    run_frame(16, 0, 1'b0, 1'b0, 1, 32'h0000_BEEF, 32'h0000_7E81, 1'b0, 1'b0);
    // Valid chip select then an out-of-range one.
    run_frame(8, 1, 1'b0, 1'b0, 0, 32'h0000_0069, 32'h0000_0096, 1'b0, 1'b0);
    run_frame(8, 3, 1'b1, 1'b0, 0, 32'h0000_0011, 32'h0000_00EE, 1'b0, 1'b0);

    for (int i = 0; i < 20; i++) begin
      run_frame($urandom_range(1, 40), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
